hazard_scoreboard: RTL and testbench

Parametrised stall controller for the 5-stage MIPS pipeline; replaces pattern-matched per-opcode stall logic with a per-register Tnew scoreboard plus an internal mult/div busy timer. Sits beside the D stage: consumes decoded Tuse/Tnew/write info of the D-stage instruction, returns a single stall (freeze PC/IF-ID, bubble into ID-EX). Opcode decoding stays in the controller; this block only tracks timing.

---
 rtl/hazard_pkg.sv | 33 +++
 rtl/md_busy_timer.sv | 33 +++
 rtl/hazard_scoreboard.sv | 92 +++++++++
 tb/tb_hazard_scoreboard.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared timing constants and Tuse/Tnew encodings for the hazard scoreboard
// and the D-stage controller that feeds it.
package hazard_pkg;

  localparam int HZ_NREG     = 32;
  localparam int HZ_REG_AW   = 5;
  localparam int HZ_T_W      = 2;
  localparam int HZ_MULT_CYC = 5;
  localparam int HZ_DIV_CYC  = 10;

  // All-ones Tuse means the operand is not read at all
  localparam logic [HZ_T_W-1:0] TUSE_NONE   = '1;
  localparam logic [HZ_T_W-1:0] TUSE_BRANCH = 2'd0;
  localparam logic [HZ_T_W-1:0] TUSE_ALU    = 2'd1;
  localparam logic [HZ_T_W-1:0] TUSE_STORE  = 2'd2;

  localparam logic [HZ_T_W-1:0] TNEW_NONE = 2'd0;
  localparam logic [HZ_T_W-1:0] TNEW_ALU  = 2'd1;
  localparam logic [HZ_T_W-1:0] TNEW_LOAD = 2'd2;

  typedef enum logic [2:0] {
    IC_ALU, IC_LOAD, IC_STORE, IC_BRANCH, IC_MFHL, IC_MD
  } instr_class_e;

  function automatic logic [HZ_T_W-1:0] tnew_of(input instr_class_e c);
    case (c)
      IC_LOAD:        return TNEW_LOAD;
      IC_ALU, IC_MFHL: return TNEW_ALU;
      default:        return TNEW_NONE;
    endcase
  endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Mult/div busy countdown: loads the unit latency on start, counts down to 0.
module md_busy_timer #(
  parameter int MD_W     = 4,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
)(
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic is_div,
  output logic md_busy
);

  logic [MD_W-1:0] md_cnt, md_nxt;

  always_comb begin
    md_nxt = md_cnt;
    if (start)               md_nxt = is_div ? MD_W'(DIV_CYC) : MD_W'(MULT_CYC);
    else if (md_cnt != '0)   md_nxt = md_cnt - 1'b1;
  end

  // busy is kept as its own flop so the output is glitch-free
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      md_cnt  <= '0;
      md_busy <= 1'b0;
    end else begin
      md_cnt  <= md_nxt;
      md_busy <= (md_nxt != '0);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-GPR Tnew scoreboard plus mult/div busy timer producing the D-stage stall.
// Define HAZARD_STATS_EN for saturating stall-cycle counter outputs.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG     = HZ_NREG,
  parameter int REG_AW   = HZ_REG_AW,
  parameter int T_W      = HZ_T_W,
  parameter int MULT_CYC = HZ_MULT_CYC,
  parameter int DIV_CYC  = HZ_DIV_CYC
)(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              d_valid,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic [T_W-1:0]    d_rs_tuse,
  input  logic [T_W-1:0]    d_rt_tuse,
  input  logic              d_wr_en,
  input  logic [REG_AW-1:0] d_wr_addr,
  input  logic [T_W-1:0]    d_tnew,
  input  logic              d_md_start,
  input  logic              d_md_is_div,
  input  logic              d_md_use,
  input  logic              flush,
  output logic              stall,
  output logic              md_busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stat_stall_cyc,
  output logic [31:0]       stat_md_stall_cyc
`endif
);

  localparam int MD_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int MD_W   = $clog2(MD_MAX + 1);
  localparam logic [T_W-1:0] TUSE_OFF = '1;

  logic [NREG-1:0][T_W-1:0] cnt;
  logic rs_haz, rt_haz, md_haz;
  logic issue;

  assign rs_haz = (d_rs_tuse != TUSE_OFF) && (d_rs != '0) && (cnt[d_rs] > d_rs_tuse);
  assign rt_haz = (d_rt_tuse != TUSE_OFF) && (d_rt != '0) && (cnt[d_rt] > d_rt_tuse);
  assign md_haz = d_md_use && md_busy;
  assign stall  = d_valid && (rs_haz || rt_haz || md_haz);
  // an instruction sitting in D during a flush is discarded, not issued
  assign issue  = d_valid && !stall && !flush;

  // Entry 0 is cleared on reset and never loaded, so $0 never creates a hazard
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (flush)
          cnt[i] <= '0;
        else if (issue && d_wr_en && d_wr_addr == REG_AW'(i))
          cnt[i] <= d_tnew;
        else if (cnt[i] != '0)
          cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  md_busy_timer #(
    .MD_W     (MD_W),
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (issue && d_md_start),
    .is_div  (d_md_is_div),
    .md_busy (md_busy)
  );

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_stall_cyc    <= '0;
      stat_md_stall_cyc <= '0;
    end else begin
      if (stall && stat_stall_cyc != '1)
        stat_stall_cyc <= stat_stall_cyc + 1'b1;
      if (stall && md_haz && stat_md_stall_cyc != '1)
        stat_md_stall_cyc <= stat_md_stall_cyc + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with a ready-time model checked every cycle.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       d_valid, d_wr_en, d_md_start, d_md_is_div, d_md_use, flush;
  logic [4:0] d_rs, d_rt, d_wr_addr;
  logic [1:0] d_rs_tuse, d_rt_tuse, d_tnew;
  logic       stall, md_busy;
`ifdef HAZARD_STATS_EN
  logic [31:0] stat_stall_cyc, stat_md_stall_cyc;
  int          m_stall_cnt = 0;
  int          m_md_stall_cnt = 0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int obs_stall = 0;

  hazard_scoreboard dut (
    .clk(clk), .reset_n(reset_n), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse), .d_wr_en(d_wr_en),
    .d_wr_addr(d_wr_addr), .d_tnew(d_tnew), .d_md_start(d_md_start),
    .d_md_is_div(d_md_is_div), .d_md_use(d_md_use), .flush(flush),
    .stall(stall), .md_busy(md_busy)
`ifdef HAZARD_STATS_EN
    , .stat_stall_cyc(stat_stall_cyc), .stat_md_stall_cyc(stat_md_stall_cyc)
`endif
  );

  always #5 clk = ~clk;

  // Model: absolute cycle at which each result / the mult-div unit becomes ready
  int cyc = 0;
  int ready_at [32];
  int md_done = 0;

  function automatic int remaining(input logic [4:0] r);
    return (ready_at[r] > cyc) ? ready_at[r] - cyc : 0;
  endfunction

  function automatic bit m_md_haz();
    return d_valid && d_md_use && (md_done > cyc);
  endfunction

  function automatic bit m_stall();
    bit rs_h, rt_h;
    rs_h = (d_rs_tuse != 2'd3) && (d_rs != 0) && (remaining(d_rs) > int'(d_rs_tuse));
    rt_h = (d_rt_tuse != 2'd3) && (d_rt != 0) && (remaining(d_rt) > int'(d_rt_tuse));
    return d_valid && (rs_h || rt_h || m_md_haz());
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < 32; r++) ready_at[r] = 0;
      md_done = 0;
      cyc = 0;
    end else begin
      bit st;
      st = m_stall();
`ifdef HAZARD_STATS_EN
      if (st) m_stall_cnt++;
      if (st && m_md_haz()) m_md_stall_cnt++;
`endif
      if (d_valid && !st && !flush) begin
        if (d_wr_en && d_wr_addr != 0) ready_at[d_wr_addr] = cyc + 1 + int'(d_tnew);
        if (d_md_start) md_done = cyc + 1 + (d_md_is_div ? 10 : 5);
      end
      if (flush) for (int r = 0; r < 32; r++) ready_at[r] = 0;
      cyc++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("stall_vs_model", 32'(stall), 32'(m_stall()));
    check("md_busy_vs_model", 32'(md_busy), 32'(md_done > cyc));
    if (stall === 1'b1) obs_stall++;
  end

  task automatic set_idle();
    d_valid = 0; d_rs = 0; d_rt = 0; d_rs_tuse = 2'd3; d_rt_tuse = 2'd3;
    d_wr_en = 0; d_wr_addr = 0; d_tnew = 0;
    d_md_start = 0; d_md_is_div = 0; d_md_use = 0;
  endtask

  task automatic set_instr(input logic [4:0] rs, input logic [1:0] rs_tu,
                           input logic [4:0] rt, input logic [1:0] rt_tu,
                           input logic wr, input logic [4:0] wa, input logic [1:0] tn,
                           input logic ms, input logic mdiv, input logic mu);
    d_valid = 1; d_rs = rs; d_rs_tuse = rs_tu; d_rt = rt; d_rt_tuse = rt_tu;
    d_wr_en = wr; d_wr_addr = wa; d_tnew = tn;
    d_md_start = ms; d_md_is_div = mdiv; d_md_use = mu;
  endtask

  // Hold the current D instruction until it issues; count stall cycles seen
  task automatic issue_wait(input string name, input int exp_st);
    int n;
    n = 0;
    @(negedge clk);
    while (stall && n < 40) begin
      n++;
      @(negedge clk);
    end
    @(posedge clk); #1;
    set_idle();
    check({name, "_stalls"}, n, exp_st);
  endtask

  task automatic idle_cycles(input int n);
    set_idle();
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    flush = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_stall", 32'(stall), 0);
    check("reset_md_busy", 32'(md_busy), 0);
    @(negedge clk); #2 reset_n = 1;
    @(posedge clk); #1;

    // lw $8 (tnew 2) then addu using $8 at tuse 1: one bubble
    set_instr(5'd29, 2'd1, 5'd0, 2'd3, 1, 5'd8, 2'd2, 0, 0, 0);
    issue_wait("lw8", 0);
    set_instr(5'd8, 2'd1, 5'd9, 2'd1, 1, 5'd10, 2'd1, 0, 0, 0);
    issue_wait("addu_after_lw", 1);

    // ori $9 then beq $9 (tuse 0): one bubble
    set_instr(5'd0, 2'd1, 5'd0, 2'd3, 1, 5'd9, 2'd1, 0, 0, 0);
    issue_wait("ori9", 0);
    set_instr(5'd9, 2'd0, 5'd10, 2'd0, 0, 5'd0, 2'd0, 0, 0, 0);
    issue_wait("beq_after_ori", 1);

    // ori $9 then sw with $9 as store data (tuse 2): no bubble
    set_instr(5'd0, 2'd1, 5'd0, 2'd3, 1, 5'd9, 2'd1, 0, 0, 0);
    issue_wait("ori9b", 0);
    set_instr(5'd29, 2'd1, 5'd9, 2'd2, 0, 5'd0, 2'd0, 0, 0, 0);
    issue_wait("sw_after_ori", 0);

    // writes to $0 never create a hazard
    set_instr(5'd0, 2'd3, 5'd0, 2'd3, 1, 5'd0, 2'd3, 0, 0, 0);
    issue_wait("wr_zero", 0);
    set_instr(5'd0, 2'd0, 5'd0, 2'd0, 0, 5'd0, 2'd0, 0, 0, 0);
    issue_wait("use_zero", 0);

    // mult then mflo: 5 bubbles; div then mfhi: 10 bubbles
    set_instr(5'd4, 2'd1, 5'd5, 2'd1, 0, 5'd0, 2'd0, 1, 0, 1);
    issue_wait("mult", 0);
    check("md_busy_after_mult", 32'(md_busy), 1);
    set_instr(5'd0, 2'd3, 5'd0, 2'd3, 1, 5'd11, 2'd1, 0, 0, 1);
    issue_wait("mflo", 5);
    check("md_busy_after_mflo", 32'(md_busy), 0);
    set_instr(5'd4, 2'd1, 5'd5, 2'd1, 0, 5'd0, 2'd0, 1, 1, 1);
    issue_wait("div", 0);
    set_instr(5'd0, 2'd3, 5'd0, 2'd3, 1, 5'd11, 2'd1, 0, 0, 1);
    issue_wait("mfhi", 10);

    // flush: pending $8 cleared, lw $12 in D during flush discarded, mult keeps running
    set_instr(5'd4, 2'd1, 5'd5, 2'd1, 0, 5'd0, 2'd0, 1, 0, 1);
    issue_wait("mult_pre_flush", 0);
    set_instr(5'd29, 2'd1, 5'd0, 2'd3, 1, 5'd8, 2'd2, 0, 0, 0);
    issue_wait("lw8_pre_flush", 0);
    set_instr(5'd29, 2'd1, 5'd0, 2'd3, 1, 5'd12, 2'd2, 0, 0, 0);
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    set_instr(5'd8, 2'd0, 5'd12, 2'd0, 0, 5'd0, 2'd0, 0, 0, 0);
    check("md_busy_after_flush", 32'(md_busy), 1);
    issue_wait("use_after_flush", 0);
    idle_cycles(6);

    // tnew 0 leaves the entry clear
    set_instr(5'd0, 2'd3, 5'd0, 2'd3, 1, 5'd13, 2'd0, 0, 0, 0);
    issue_wait("tnew0", 0);
    set_instr(5'd13, 2'd0, 5'd0, 2'd3, 0, 5'd0, 2'd0, 0, 0, 0);
    issue_wait("use_tnew0", 0);

    // self-dependency sees the pre-issue count, new value next cycle
    set_instr(5'd29, 2'd1, 5'd0, 2'd3, 1, 5'd14, 2'd2, 0, 0, 0);
    issue_wait("lw14", 0);
    set_instr(5'd14, 2'd1, 5'd0, 2'd3, 1, 5'd14, 2'd2, 0, 0, 0);
    issue_wait("self_dep", 1);
    set_instr(5'd14, 2'd1, 5'd0, 2'd3, 0, 5'd0, 2'd0, 0, 0, 0);
    issue_wait("use_self_dep", 1);

    // reset mid-stall with cnt[8]=2 and the div timer at 7
    set_instr(5'd4, 2'd1, 5'd5, 2'd1, 0, 5'd0, 2'd0, 1, 1, 1);
    issue_wait("div_pre_reset", 0);
    idle_cycles(2);
    set_instr(5'd29, 2'd1, 5'd0, 2'd3, 1, 5'd8, 2'd2, 0, 0, 0);
    issue_wait("lw8_pre_reset", 0);
    check("total_stall_cycles", obs_stall, 19);
`ifdef HAZARD_STATS_EN
    check("stat_stall_vs_model", stat_stall_cyc, m_stall_cnt);
    check("stat_md_stall_vs_model", stat_md_stall_cyc, m_md_stall_cnt);
    check("stat_stall_total", stat_stall_cyc, 19);
    check("stat_md_stall_total", stat_md_stall_cyc, 15);
`endif
    set_instr(5'd8, 2'd0, 5'd0, 2'd3, 1, 5'd15, 2'd1, 0, 0, 1);
    @(negedge clk);
    check("stall_before_reset", 32'(stall), 1);
    check("md_busy_before_reset", 32'(md_busy), 1);
    #2 reset_n = 0;
    #1;
    check("stall_in_reset", 32'(stall), 0);
    check("md_busy_in_reset", 32'(md_busy), 0);
`ifdef HAZARD_STATS_EN
    check("stat_stall_reset", stat_stall_cyc, 0);
    check("stat_md_stall_reset", stat_md_stall_cyc, 0);
`endif
    @(negedge clk); #2 reset_n = 1;
    @(posedge clk); #1;
    issue_wait("mfhi_after_reset", 0);
    idle_cycles(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
